// File: rtl/mi_nios_cpu_nios2_oci_trace_fifo.sv
// ---------------------------------------------------------------------------
// mi_nios_cpu_nios2_oci_trace_fifo
//
// Purpose:
//   Multi-lane trace FIFO for the OCI trace path. The block sits between the
//   trace packer and the trace read-out / JTAG side.
//   - It accepts 0..LANES entries per cycle.
//   - It drains one entry per cycle on request, with show-ahead read data.
//   - When free space is short, it accepts only the lowest lanes that fit.
//   - It records every dropped entry in a sticky overflow flag and in a
//     saturating drop counter.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in_cnt      number of valid lanes this cycle (clamped to LANES)
//   in_data     lane i at [i*WIDTH +: WIDTH]
//   rd_en       pop request (ignored when empty)
//   ovf_clr     clears overflow and drop_cnt (a same-cycle drop wins)
//   rd_data     head entry, 0 when empty
//   empty/full  occupancy flags
//   fifo_cnt    registered occupancy
//   free_cnt    DEPTH - fifo_cnt
//   accept_cnt  entries accepted this cycle (combinational)
//   overflow    sticky drop flag
//   drop_cnt    saturating dropped-entry count
// ---------------------------------------------------------------------------
module mi_nios_cpu_nios2_oci_trace_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 32,
  parameter int LANES = 3,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int LW   = $clog2(LANES + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LW-1:0]          in_cnt,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [CW-1:0]          fifo_cnt,
  output logic [CW-1:0]          free_cnt,
  output logic [LW-1:0]          accept_cnt,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_fifo_cnt;
  logic             r_overflow;
  logic [15:0]      r_drop_cnt;

  logic [LW-1:0]    w_in_clamp;
  logic             w_empty;
  logic             w_rd_fire;
  logic [CW-1:0]    w_free;
  logic [CW:0]      w_free_eff;
  logic [LW-1:0]    w_accept;
  logic [LW-1:0]    w_dropped;
  logic [CW-1:0]    w_cnt_next;
  logic [15:0]      w_drop_base;
  logic [16:0]      w_drop_sum;
  logic [15:0]      w_drop_next;

  assign w_empty   = (r_fifo_cnt == CW'(0));
  assign w_rd_fire = rd_en & ~w_empty;
  assign w_free    = CW'(DEPTH) - r_fifo_cnt;
  // A slot popped this cycle is reusable by this cycle's writes.
  assign w_free_eff = {1'b0, w_free} + {{CW{1'b0}}, w_rd_fire};

  // Clamp the requested lane count to the number of physical lanes.
  always_comb begin
    w_in_clamp = in_cnt;
    if (in_cnt > LW'(LANES)) begin
      w_in_clamp = LW'(LANES);
    end else begin
      w_in_clamp = in_cnt;
    end
  end

  // Accept the lowest lanes that fit into the effective free space.
  always_comb begin
    w_accept = w_in_clamp;
    if ((CW+1)'(w_in_clamp) <= w_free_eff) begin
      w_accept = w_in_clamp;
    end else begin
      w_accept = LW'(w_free_eff);
    end
  end

  assign w_dropped  = w_in_clamp - w_accept;
  assign w_cnt_next = r_fifo_cnt + CW'(w_accept) - CW'(w_rd_fire);

  // A clear in the same cycle as a drop restarts the count from the new drops.
  assign w_drop_base = ovf_clr ? 16'h0000 : r_drop_cnt;
  assign w_drop_sum  = {1'b0, w_drop_base} + 17'(w_dropped);

  // Saturate the drop counter at all-ones.
  always_comb begin
    w_drop_next = w_drop_sum[15:0];
    if (w_drop_sum[16]) begin
      w_drop_next = 16'hFFFF;
    end else begin
      w_drop_next = w_drop_sum[15:0];
    end
  end

  // Pointers, occupancy and drop accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= AW'(0);
      r_rd_ptr   <= AW'(0);
      r_fifo_cnt <= CW'(0);
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'h0000;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_accept);
      r_rd_ptr   <= r_rd_ptr + AW'(w_rd_fire);
      r_fifo_cnt <= w_cnt_next;
      if (w_dropped != LW'(0)) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_next;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 16'h0000;
      end else begin
        r_overflow <= r_overflow;
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  // Storage writes. The array is not reset. Accepted lanes go to
  // consecutive slots, which wrap modulo DEPTH through the pointer width.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(w_accept)) begin
        r_mem[r_wr_ptr + AW'(i)] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data    = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign empty      = w_empty;
  assign full       = (r_fifo_cnt == CW'(DEPTH));
  assign fifo_cnt   = r_fifo_cnt;
  assign free_cnt   = w_free;
  assign accept_cnt = w_accept;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_mi_nios_cpu_nios2_oci_trace_fifo.sv
module tb_mi_nios_cpu_nios2_oci_trace_fifo;

  localparam int W = 36;
  localparam int D = 32;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     in_cnt;
  logic [L*W-1:0] in_data;
  logic           rd_en;
  logic           ovf_clr;
  logic [W-1:0]   rd_data;
  logic           empty;
  logic           full;
  logic [5:0]     fifo_cnt;
  logic [5:0]     free_cnt;
  logic [1:0]     accept_cnt;
  logic           overflow;
  logic [15:0]    drop_cnt;

  always #5 clk = ~clk;

  mi_nios_cpu_nios2_oci_trace_fifo #(.WIDTH(W), .DEPTH(D), .LANES(L)) dut (
    .clk(clk), .reset(reset), .in_cnt(in_cnt), .in_data(in_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty),
    .full(full), .fifo_cnt(fifo_cnt), .free_cnt(free_cnt),
    .accept_cnt(accept_cnt), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus overflow and drop totals.
  logic [W-1:0] q[$];
  bit           m_ovf;
  int           m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_accept();
    int clamp = (int'(in_cnt) > L) ? L : int'(in_cnt);
    int rdf   = (rd_en && q.size() > 0) ? 1 : 0;
    int eff   = D - q.size() + rdf;
    return (clamp < eff) ? clamp : eff;
  endfunction

  task automatic compare_model();
    int n = q.size();
    chk("rd_data",  64'(rd_data),  (n > 0) ? 64'(q[0]) : 64'd0);
    chk("empty",    64'(empty),    64'(n == 0));
    chk("full",     64'(full),     64'(n == D));
    chk("fifo_cnt", 64'(fifo_cnt), 64'(n));
    chk("free_cnt", 64'(free_cnt), 64'(D - n));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // Apply inputs just after a falling edge, then check state and acceptance.
  task automatic drive(input int cnt, input bit rd, input bit clr, input logic [L*W-1:0] d);
    in_cnt  = 2'(cnt);
    rd_en   = rd;
    ovf_clr = clr;
    in_data = d;
    #1;
    compare_model();
    chk("accept_cnt", 64'(accept_cnt), 64'(model_accept()));
  endtask

  // Advance the model by one cycle, then cross one rising edge.
  task automatic tick();
    int acc   = model_accept();
    int clamp = (int'(in_cnt) > L) ? L : int'(in_cnt);
    int dr    = clamp - acc;
    if (rd_en && q.size() > 0) void'(q.pop_front());
    for (int i = 0; i < acc; i++) q.push_back(in_data[i*W +: W]);
    if (dr > 0) begin
      m_ovf  = 1'b1;
      m_drop = (ovf_clr ? 0 : m_drop) + dr;
      if (m_drop > 65535) m_drop = 65535;
    end else if (ovf_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [L*W-1:0] rnd_data();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = {4'($urandom), $urandom};
    return v;
  endfunction

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      drive(0, 1'b1, 1'b0, '0);
      tick();
    end
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  logic [W-1:0] va, vb, vc, vx;

  initial begin
    reset = 1'b1; in_cnt = 2'd0; in_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0; m_drop = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_free_cnt", 64'(free_cnt), 64'd32);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    // Three-lane write, then three pops in order.
    va = 36'hA_0000_000A; vb = 36'hB_0000_000B; vc = 36'hC_0000_000C;
    drive(3, 1'b0, 1'b0, {vc, vb, va});
    chk("abc_accept", 64'(accept_cnt), 64'd3);
    tick();
    drive(0, 1'b1, 1'b0, '0);
    chk("abc_cnt", 64'(fifo_cnt), 64'd3);
    chk("pop_a", 64'(rd_data), 64'(va));
    tick();
    drive(0, 1'b1, 1'b0, '0);
    chk("pop_b", 64'(rd_data), 64'(vb));
    tick();
    drive(0, 1'b1, 1'b0, '0);
    chk("pop_c", 64'(rd_data), 64'(vc));
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("abc_empty", 64'(empty), 64'd1);
    chk("abc_rd_zero", 64'(rd_data), 64'd0);
    tick();

    // Partial acceptance at 30, then full-with-pop, then clear priority.
    for (int k = 0; k < 10; k++) begin drive(3, 1'b0, 1'b0, rnd_data()); tick(); end
    drive(3, 1'b0, 1'b0, rnd_data());
    chk("fill30_cnt", 64'(fifo_cnt), 64'd30);
    chk("fill30_accept", 64'(accept_cnt), 64'd2);
    tick();
    drive(3, 1'b1, 1'b0, rnd_data());
    chk("full_cnt", 64'(fifo_cnt), 64'd32);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_drop1", 64'(drop_cnt), 64'd1);
    chk("fullrd_accept", 64'(accept_cnt), 64'd1);
    tick();
    drive(3, 1'b0, 1'b1, rnd_data());
    chk("fullrd_cnt", 64'(fifo_cnt), 64'd32);
    chk("fullrd_drop3", 64'(drop_cnt), 64'd3);
    tick();
    drive(0, 1'b0, 1'b1, '0);
    chk("clr_set_wins_ovf", 64'(overflow), 64'd1);
    chk("clr_set_wins_drop", 64'(drop_cnt), 64'd3);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    tick();

    // Write into empty while reading: the read is ignored.
    drain();
    drive(2, 1'b1, 1'b0, rnd_data());
    chk("wempty_empty", 64'(empty), 64'd1);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("wempty_cnt", 64'(fifo_cnt), 64'd2);
    tick();

    // Random traffic over many pointer wraps.
    for (int k = 0; k < 500; k++) begin
      drive(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, rnd_data());
      tick();
    end

    // Reset mid-burst with 17 entries stored.
    drain();
    for (int k = 0; k < 5; k++) begin drive(3, 1'b0, 1'b0, rnd_data()); tick(); end
    drive(2, 1'b0, 1'b0, rnd_data());
    tick();
    drive(3, 1'b0, 1'b0, rnd_data());
    chk("pre_rst_cnt", 64'(fifo_cnt), 64'd17);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", 64'(fifo_cnt), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_free", 64'(free_cnt), 64'd32);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    q.delete(); m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    vx = 36'h5_1234_5678;
    drive(1, 1'b0, 1'b0, {72'd0, vx});
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("post_rst_data", 64'(rd_data), 64'(vx));
    tick();

    // Saturation of the drop counter.
    for (int k = 0; k < 11; k++) begin drive(3, 1'b0, 1'b0, rnd_data()); tick(); end
    for (int k = 0; k < 30000 && m_drop < 65534; k++) begin
      drive((65534 - m_drop) < 3 ? (65534 - m_drop) : 3, 1'b0, 1'b0, '0);
      tick();
    end
    drive(3, 1'b0, 1'b0, '0);
    chk("sat_fffe", 64'(drop_cnt), 64'hFFFE);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("sat_ffff", 64'(drop_cnt), 64'hFFFF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
